mcycle_controller: RTL and testbench

Moore-style multicycle control FSM that sequences the 16-bit datapath: it fetches each instruction, steps it through decode, execute, memory and write-back, and drives every datapath select and enable line. It also owns the architectural Z flag used by conditional branches. It sits beside the datapath in the CPU top level, between the instruction/data memory port and the datapath control inputs.

---
 rtl/mcycle_controller.sv | 200 ++++++++++++++++++++
 tb/tb_mcycle_controller.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mcycle_controller.sv
// Multicycle control FSM for the 16-bit datapath: sequences fetch/decode/execute/
// memory/write-back, drives all datapath selects and enables, and owns the Z flag.
module mcycle_controller #(
  parameter int WIDTH         = 16,
  parameter int ALU_CONT_BITS = 5,
  parameter int OP_BITS       = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [OP_BITS-1:0]       op_code,
  input  logic [OP_BITS-1:0]       ext_op_code,
  input  logic [3:0]               cond,
  input  logic                     zero,
  output logic                     ir_write,
  output logic                     mem_write,
  output logic                     pc_en,
  output logic                     pc_src,
  output logic                     reg_write,
  output logic                     reg_write_src,
  output logic                     address_src,
  output logic                     alu_A_src,
  output logic [1:0]               alu_B_src,
  output logic [ALU_CONT_BITS-1:0] alu_cont,
  output logic [3:0]               state,
  output logic                     z_flag
);

  typedef enum logic [3:0] {
    FETCH      = 4'd0,
    FETCH_WAIT = 4'd1,
    DECODE     = 4'd2,
    EXEC_RR    = 4'd3,
    EXEC_RI    = 4'd4,
    ALU_WB     = 4'd5,
    MEM_READ   = 4'd6,
    MEM_WAIT   = 4'd7,
    MEM_WB     = 4'd8,
    MEM_WRITE  = 4'd9,
    BRANCH     = 4'd10,
    BRANCH_WB  = 4'd11,
    JUMP       = 4'd12
  } state_t;

  localparam logic [OP_BITS-1:0] OP_RR   = OP_BITS'(4'b0000);
  localparam logic [OP_BITS-1:0] OP_ADD  = OP_BITS'(4'b0101);
  localparam logic [OP_BITS-1:0] OP_SUB  = OP_BITS'(4'b1001);
  localparam logic [OP_BITS-1:0] OP_CMP  = OP_BITS'(4'b1011);
  localparam logic [OP_BITS-1:0] OP_AND  = OP_BITS'(4'b0001);
  localparam logic [OP_BITS-1:0] OP_OR   = OP_BITS'(4'b0010);
  localparam logic [OP_BITS-1:0] OP_XOR  = OP_BITS'(4'b0011);
  localparam logic [OP_BITS-1:0] OP_MOV  = OP_BITS'(4'b1101);
  localparam logic [OP_BITS-1:0] OP_SPEC = OP_BITS'(4'b0100);
  localparam logic [OP_BITS-1:0] OP_BCC  = OP_BITS'(4'b1100);
  localparam logic [OP_BITS-1:0] EXT_LOAD = OP_BITS'(4'b0000);
  localparam logic [OP_BITS-1:0] EXT_STOR = OP_BITS'(4'b0100);
  localparam logic [OP_BITS-1:0] EXT_JUMP = OP_BITS'(4'b1100);

  localparam logic [ALU_CONT_BITS-1:0] ALU_ADD    = ALU_CONT_BITS'(0);
  localparam logic [ALU_CONT_BITS-1:0] ALU_SUB    = ALU_CONT_BITS'(1);
  localparam logic [ALU_CONT_BITS-1:0] ALU_AND    = ALU_CONT_BITS'(2);
  localparam logic [ALU_CONT_BITS-1:0] ALU_OR     = ALU_CONT_BITS'(3);
  localparam logic [ALU_CONT_BITS-1:0] ALU_XOR    = ALU_CONT_BITS'(4);
  localparam logic [ALU_CONT_BITS-1:0] ALU_PASS_B = ALU_CONT_BITS'(5);

  localparam logic [1:0] B_REG = 2'd0;
  localparam logic [1:0] B_IMM = 2'd1;
  localparam logic [1:0] B_ONE = 2'd2;

  // Instruction fields are 4-bit slices of a 16-bit word.
  if (WIDTH < 16 || OP_BITS < 4 || ALU_CONT_BITS < 3) begin : g_param_check
    $error("mcycle_controller: unsupported parameter combination");
  end

  function automatic logic is_alu_op(input logic [OP_BITS-1:0] code);
    case (code)
      OP_ADD, OP_SUB, OP_CMP, OP_AND, OP_OR, OP_XOR, OP_MOV: return 1'b1;
      default:                                                return 1'b0;
    endcase
  endfunction

  function automatic logic [ALU_CONT_BITS-1:0] alu_op_cont(input logic [OP_BITS-1:0] code);
    case (code)
      OP_SUB, OP_CMP: return ALU_SUB;
      OP_AND:         return ALU_AND;
      OP_OR:          return ALU_OR;
      OP_XOR:         return ALU_XOR;
      OP_MOV:         return ALU_PASS_B;
      default:        return ALU_ADD;
    endcase
  endfunction

  state_t cur_state;
  state_t next_state;
  logic   branch_taken;
  logic   cmp_exec;

  assign state = cur_state;

  assign branch_taken = (cond == 4'b0000 && z_flag) ||
                        (cond == 4'b0001 && !z_flag) ||
                        (cond == 4'b1110);

  assign cmp_exec = (cur_state == EXEC_RR && ext_op_code == OP_CMP) ||
                    (cur_state == EXEC_RI && op_code == OP_CMP);

  always_comb begin
    next_state = FETCH;
    case (cur_state)
      FETCH:      next_state = FETCH_WAIT;
      FETCH_WAIT: next_state = DECODE;
      DECODE: begin
        if (op_code == OP_RR)          next_state = EXEC_RR;
        else if (is_alu_op(op_code))   next_state = EXEC_RI;
        else if (op_code == OP_SPEC) begin
          case (ext_op_code)
            EXT_LOAD: next_state = MEM_READ;
            EXT_STOR: next_state = MEM_WRITE;
            EXT_JUMP: next_state = JUMP;
            default:  next_state = FETCH;
          endcase
        end
        else if (op_code == OP_BCC)    next_state = BRANCH;
        else                           next_state = FETCH;
      end
      EXEC_RR:  next_state = (is_alu_op(ext_op_code) && ext_op_code != OP_CMP) ? ALU_WB : FETCH;
      EXEC_RI:  next_state = (op_code != OP_CMP) ? ALU_WB : FETCH;
      MEM_READ: next_state = MEM_WAIT;
      MEM_WAIT: next_state = MEM_WB;
      BRANCH:   next_state = branch_taken ? BRANCH_WB : FETCH;
      default:  next_state = FETCH;
    endcase
  end

  // Outputs are registered from next_state so they are valid for the whole
  // state they belong to, exactly as a decode of cur_state would be.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state     <= FETCH;
      z_flag        <= 1'b0;
      ir_write      <= 1'b0;
      mem_write     <= 1'b0;
      pc_en         <= 1'b0;
      pc_src        <= 1'b0;
      reg_write     <= 1'b0;
      reg_write_src <= 1'b0;
      address_src   <= 1'b0;
      alu_A_src     <= 1'b0;
      alu_B_src     <= B_ONE;
      alu_cont      <= ALU_ADD;
    end else begin
      cur_state <= next_state;
      if (cmp_exec) z_flag <= zero;

      ir_write      <= 1'b0;
      mem_write     <= 1'b0;
      pc_en         <= 1'b0;
      pc_src        <= 1'b0;
      reg_write     <= 1'b0;
      reg_write_src <= 1'b0;
      address_src   <= 1'b0;
      alu_A_src     <= 1'b0;
      alu_B_src     <= B_REG;
      alu_cont      <= ALU_ADD;
      case (next_state)
        FETCH:      alu_B_src <= B_ONE;
        FETCH_WAIT: begin
          ir_write <= 1'b1;
          pc_en    <= 1'b1;
        end
        EXEC_RR: begin
          alu_A_src <= 1'b1;
          alu_cont  <= alu_op_cont(ext_op_code);
        end
        EXEC_RI: begin
          alu_A_src <= 1'b1;
          alu_B_src <= B_IMM;
          alu_cont  <= alu_op_cont(op_code);
        end
        ALU_WB:   reg_write <= 1'b1;
        MEM_READ, MEM_WAIT: address_src <= 1'b1;
        MEM_WB: begin
          reg_write     <= 1'b1;
          reg_write_src <= 1'b1;
        end
        MEM_WRITE: begin
          address_src <= 1'b1;
          mem_write   <= 1'b1;
        end
        BRANCH:    alu_B_src <= B_IMM;
        BRANCH_WB: pc_en <= 1'b1;
        JUMP: begin
          pc_en  <= 1'b1;
          pc_src <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mcycle_controller.sv
// Directed bench for mcycle_controller: walks each instruction class cycle by
// cycle and compares state, control vector and z_flag against hand-written values.
module tb_mcycle_controller;

  logic       clk;
  logic       reset;
  logic [3:0] op_code;
  logic [3:0] ext_op_code;
  logic [3:0] cond;
  logic       zero;
  logic       ir_write, mem_write, pc_en, pc_src, reg_write, reg_write_src;
  logic       address_src, alu_A_src;
  logic [1:0] alu_B_src;
  logic [4:0] alu_cont;
  logic [3:0] state;
  logic       z_flag;

  int unsigned n_checks;
  int unsigned n_errors;

  mcycle_controller #(.WIDTH(16), .ALU_CONT_BITS(5), .OP_BITS(4)) dut (
    .clk(clk), .reset(reset), .op_code(op_code), .ext_op_code(ext_op_code),
    .cond(cond), .zero(zero), .ir_write(ir_write), .mem_write(mem_write),
    .pc_en(pc_en), .pc_src(pc_src), .reg_write(reg_write),
    .reg_write_src(reg_write_src), .address_src(address_src),
    .alu_A_src(alu_A_src), .alu_B_src(alu_B_src), .alu_cont(alu_cont),
    .state(state), .z_flag(z_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {ir_write, mem_write, pc_en, pc_src, reg_write, reg_write_src, address_src, alu_A_src, alu_B_src, alu_cont}
  logic [14:0] ctl;
  assign ctl = {ir_write, mem_write, pc_en, pc_src, reg_write, reg_write_src,
                address_src, alu_A_src, alu_B_src, alu_cont};

  localparam logic [14:0] C_FETCH  = {8'b0000_0000, 2'd2, 5'd0};
  localparam logic [14:0] C_FWAIT  = {8'b1010_0000, 2'd0, 5'd0};
  localparam logic [14:0] C_DECODE = {8'b0000_0000, 2'd0, 5'd0};
  localparam logic [14:0] C_ALUWB  = {8'b0000_1000, 2'd0, 5'd0};
  localparam logic [14:0] C_MEMRD  = {8'b0000_0010, 2'd0, 5'd0};
  localparam logic [14:0] C_MEMWB  = {8'b0000_1100, 2'd0, 5'd0};
  localparam logic [14:0] C_MEMWR  = {8'b0100_0010, 2'd0, 5'd0};
  localparam logic [14:0] C_BRANCH = {8'b0000_0000, 2'd1, 5'd0};
  localparam logic [14:0] C_BRWB   = {8'b0010_0000, 2'd0, 5'd0};
  localparam logic [14:0] C_JUMP   = {8'b0011_0000, 2'd0, 5'd0};

  function automatic logic [14:0] c_exec_rr(input logic [4:0] alu);
    return {8'b0000_0001, 2'd0, alu};
  endfunction

  function automatic logic [14:0] c_exec_ri(input logic [4:0] alu);
    return {8'b0000_0001, 2'd1, alu};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge: check the current state and controls, then move one cycle.
  task automatic expect_cycle(input string tag, input logic [3:0] st, input logic [14:0] c);
    check({tag, "_state"}, 32'(state), 32'(st));
    check({tag, "_ctl"}, 32'(ctl), 32'(c));
    @(negedge clk);
  endtask

  task automatic expect_fetch(input string tag);
    expect_cycle({tag, "_f"},  4'd0, C_FETCH);
    expect_cycle({tag, "_fw"}, 4'd1, C_FWAIT);
    expect_cycle({tag, "_d"},  4'd2, C_DECODE);
  endtask

  task automatic set_instr(input logic [3:0] op, input logic [3:0] ext,
                           input logic [3:0] cnd, input logic z);
    op_code = op; ext_op_code = ext; cond = cnd; zero = z;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    set_instr(4'h0, 4'h0, 4'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("reset_state", 32'(state), 32'd0);
    check("reset_ctl", 32'(ctl), 32'(C_FETCH));
    check("reset_z", 32'(z_flag), 32'd0);
    reset = 1'b0;

    // RR ADD
    set_instr(4'b0000, 4'b0101, 4'h0, 1'b0);
    expect_fetch("add");
    expect_cycle("add_ex", 4'd3, c_exec_rr(5'd0));
    expect_cycle("add_wb", 4'd5, C_ALUWB);

    // RI MOV uses PASS_B
    set_instr(4'b1101, 4'h0, 4'h0, 1'b0);
    expect_fetch("mov");
    expect_cycle("mov_ex", 4'd4, c_exec_ri(5'd5));
    expect_cycle("mov_wb", 4'd5, C_ALUWB);

    // CMPI with zero=1 sets Z
    set_instr(4'b1011, 4'h0, 4'h0, 1'b1);
    expect_fetch("cmpi1");
    check("cmpi1_z_before", 32'(z_flag), 32'd0);
    expect_cycle("cmpi1_ex", 4'd4, c_exec_ri(5'd1));
    check("cmpi1_z_after", 32'(z_flag), 32'd1);

    // BEQ taken
    set_instr(4'b1100, 4'h0, 4'b0000, 1'b0);
    expect_fetch("beq_t");
    expect_cycle("beq_t_br", 4'd10, C_BRANCH);
    expect_cycle("beq_t_wb", 4'd11, C_BRWB);
    check("beq_t_z", 32'(z_flag), 32'd1);

    // CMPI with zero=0 clears Z, BEQ not taken
    set_instr(4'b1011, 4'h0, 4'h0, 1'b0);
    expect_fetch("cmpi0");
    expect_cycle("cmpi0_ex", 4'd4, c_exec_ri(5'd1));
    check("cmpi0_z", 32'(z_flag), 32'd0);
    set_instr(4'b1100, 4'h0, 4'b0000, 1'b1);
    expect_fetch("beq_n");
    expect_cycle("beq_n_br", 4'd10, C_BRANCH);
    check("beq_n_back", 32'(state), 32'd0);

    // BNE taken with Z=0, unconditional taken with Z=0
    set_instr(4'b1100, 4'h0, 4'b0001, 1'b0);
    expect_fetch("bne");
    expect_cycle("bne_br", 4'd10, C_BRANCH);
    expect_cycle("bne_wb", 4'd11, C_BRWB);
    set_instr(4'b1100, 4'h0, 4'b1110, 1'b0);
    expect_fetch("bal");
    expect_cycle("bal_br", 4'd10, C_BRANCH);
    expect_cycle("bal_wb", 4'd11, C_BRWB);

    // LOAD: 6 cycles
    set_instr(4'b0100, 4'b0000, 4'h0, 1'b1);
    expect_fetch("ld");
    expect_cycle("ld_rd", 4'd6, C_MEMRD);
    expect_cycle("ld_wt", 4'd7, C_MEMRD);
    expect_cycle("ld_wb", 4'd8, C_MEMWB);

    // STOR and JUMP leave Z alone
    set_instr(4'b0100, 4'b0100, 4'h0, 1'b1);
    expect_fetch("st");
    expect_cycle("st_wr", 4'd9, C_MEMWR);
    set_instr(4'b0100, 4'b1100, 4'h0, 1'b1);
    expect_fetch("jmp");
    expect_cycle("jmp_j", 4'd12, C_JUMP);
    check("st_jmp_z", 32'(z_flag), 32'd0);

    // RI SUB with zero=1 must not touch Z; RR AND/XOR mapping
    set_instr(4'b1001, 4'h0, 4'h0, 1'b1);
    expect_fetch("subi");
    expect_cycle("subi_ex", 4'd4, c_exec_ri(5'd1));
    expect_cycle("subi_wb", 4'd5, C_ALUWB);
    check("subi_z", 32'(z_flag), 32'd0);
    set_instr(4'b0000, 4'b0011, 4'h0, 1'b0);
    expect_fetch("xor");
    expect_cycle("xor_ex", 4'd3, c_exec_rr(5'd4));
    expect_cycle("xor_wb", 4'd5, C_ALUWB);

    // RR undefined ext: no write-back
    set_instr(4'b0000, 4'b0111, 4'h0, 1'b0);
    expect_fetch("rrbad");
    check("rrbad_ex_state", 32'(state), 32'd3);
    check("rrbad_ex_strobes", 32'({reg_write, mem_write, pc_en}), 32'd0);
    @(negedge clk);
    check("rrbad_back", 32'(state), 32'd0);

    // RR CMP with zero=1 sets Z via the RR path
    set_instr(4'b0000, 4'b1011, 4'h0, 1'b1);
    expect_fetch("cmprr");
    expect_cycle("cmprr_ex", 4'd3, c_exec_rr(5'd1));
    check("cmprr_z", 32'(z_flag), 32'd1);

    // Reset in the middle of MEM_WAIT
    set_instr(4'b0100, 4'b0000, 4'h0, 1'b0);
    expect_fetch("ldrst");
    expect_cycle("ldrst_rd", 4'd6, C_MEMRD);
    check("ldrst_wait", 32'(state), 32'd7);
    reset = 1'b1;
    #1;
    check("ldrst_state", 32'(state), 32'd0);
    check("ldrst_z", 32'(z_flag), 32'd0);
    check("ldrst_ctl", 32'(ctl), 32'(C_FETCH));
    @(negedge clk);
    check("ldrst_held", 32'(state), 32'd0);
    set_instr(4'b1111, 4'h0, 4'h0, 1'b0);
    reset = 1'b0;

    // Undefined op: back to FETCH after DECODE
    expect_fetch("nop");
    expect_cycle("nop_back", 4'd0, C_FETCH);
    check("nop_next", 32'(state), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
